// File: rtl/uart_pkg.sv
// Shared UART types: transmitter and receiver state enums plus a width helper.
// Optional build macro: UART_RX_PARITY_EN adds the receiver PARITY state.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;
`else
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;
`endif

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned width_for(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both reset to the line's idle level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_BITS data (LSB first), optional even parity, 1 stop.
// Optional build macro: UART_RX_PARITY_EN adds the parity bit and rx_parity_err.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RX_IDLE   | line idle; waits for a low level while armed
// RX_START  | half-bit wait, then confirms the start bit is still low
// RX_DATA   | samples DATA_BITS bits at mid-bit
// RX_PARITY | samples the even-parity bit (parity builds only)
// RX_STOP   | samples the stop bit; emits rx_valid or rx_frame_err
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50000000,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 rx_frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 rx_parity_err
`endif
);

  localparam int unsigned BIT_CYCLES  = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
  localparam int unsigned CNT_W       = width_for(BIT_CYCLES);
  localparam int unsigned IDX_W       = width_for(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t            state_q, state_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 armed_q, armed_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n;
  logic                 ferr_n;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_n;
  logic                 perr_n;
`endif

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  // Busy is purely a state decode so it falls on the same edge the pulses rise.
  assign rx_busy = (state_q != RX_IDLE);

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      armed_q      <= 1'b1;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      idx_q        <= idx_n;
      shift_q      <= shift_n;
      armed_q      <= armed_n;
      rx_data      <= data_n;
      rx_valid     <= valid_n;
      rx_frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= par_bad_n;
      rx_parity_err <= perr_n;
`endif
    end
  end

  // Next-state and datapath decode; everything holds unless a branch says otherwise.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    shift_n = shift_q;
    armed_n = armed_q;
    data_n  = rx_data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad_q;
    perr_n    = 1'b0;
`endif

    case (state_q)
      RX_IDLE: begin
        // After a frame error the line must be seen high before a new start counts.
        if (!armed_q) begin
          if (rx_s) armed_n = 1'b1;
        end else if (!rx_s) begin
          state_n = RX_START;
          cnt_n   = '0;
        end
      end

      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n = RX_DATA;
            idx_n   = '0;
          end else begin
            state_n = RX_IDLE;
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_n          = '0;
          shift_n[idx_q] = rx_s;
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_n = RX_PARITY;
`else
            state_n = RX_STOP;
`endif
          end else begin
            idx_n = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_n     = '0;
          par_bad_n = (^shift_q) ^ rx_s;
          state_n   = RX_STOP;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
`endif

      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = RX_IDLE;
          if (rx_s) begin
            data_n  = shift_q;
            valid_n = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_n  = par_bad_q;
`endif
          end else begin
            ferr_n  = 1'b1;
            armed_n = 1'b0;
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_n = RX_IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected events, a monitor pops them.
module tb_uart_rx;

  localparam int CF   = 160;
  localparam int BR   = 10;
  localparam int BITC = CF / BR;
  localparam int DB   = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          rx = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_busy;
  logic          rx_frame_err;
`ifdef UART_RX_PARITY_EN
  logic          rx_parity_err;
`endif

  always #5 clock = ~clock;

  uart_rx #(.BAUD_RATE(BR), .CLOCK_FREQ(CF), .DATA_BITS(DB)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .rx_parity_err(rx_parity_err)
`endif
  );

  typedef struct {
    bit          is_err;
    bit [DB-1:0] data;
    bit          perr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit [DB-1:0] last_good = '0;
  logic        valid_prev = 1'b0;
  logic        ferr_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pulse widths, exclusivity, and in-order match against the expected queue.
  always @(negedge clock) begin
    exp_t e;
    if (valid_prev) check("valid_width", rx_valid, 0);
    if (ferr_prev)  check("ferr_width", rx_frame_err, 0);
    if (rx_valid || rx_frame_err) begin
      check("valid_ferr_exclusive", rx_valid & rx_frame_err, 0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: valid=%0b ferr=%0b data=%0h, expected none at %0t",
                 rx_valid, rx_frame_err, rx_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("event_is_err", rx_frame_err, e.is_err);
        check("rx_data", rx_data, e.data);
`ifdef UART_RX_PARITY_EN
        check("parity_err", rx_parity_err, e.perr);
`endif
      end
    end
    valid_prev <= rx_valid;
    ferr_prev  <= rx_frame_err;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_bit(input bit b);
    rx = b;
    repeat (BITC) @(negedge clock);
  endtask

  // Serialize one frame; the expected outcome follows from the frame alone.
  task automatic send_frame(input logic [DB-1:0] d, input bit stop_ok, input bit par_corrupt);
    exp_t e;
    e.is_err = !stop_ok;
    e.data   = stop_ok ? d : last_good;
    e.perr   = stop_ok & par_corrupt;
    exp_q.push_back(e);
    if (stop_ok) last_good = d;
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_corrupt);
`endif
    drive_bit(stop_ok);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DB-1:0] v;
    rx = 1'b1;
    reset_n = 1'b0;
    idle(3);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_busy", rx_busy, 0);
    check("reset_rx_frame_err", rx_frame_err, 0);
    reset_n = 1'b1;
    idle(20);
    check("no_spurious_start", rx_busy, 0);

    // Good frame.
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(5);

    // Short low glitch: start is rejected at the half-bit sample.
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(1);
    check("glitch_busy_high", rx_busy, 1);
    idle(10);
    check("glitch_busy_cleared", rx_busy, 0);
    idle(10);

    // Bad stop bit followed by a line break: one error, no re-triggering.
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(100);
    check("break_not_busy", rx_busy, 0);
    rx = 1'b1;
    idle(20);

    // Back-to-back frames.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    idle(10);

    // Random frames with random idle gaps, some back-to-back.
    for (int k = 0; k < 20; k++) begin
      v = DB'($urandom);
      send_frame(v, 1'b1, 1'b0);
      rx = 1'b1;
      idle($urandom_range(0, 30));
    end
    idle(10);

    // Reset in the middle of data bit 4 of 0x81.
    v = 8'h81;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(v[i]);
    rx = v[4];
    idle(BITC / 2);
    reset_n = 1'b0;
    idle(2);
    check("midreset_rx_data", rx_data, 0);
    check("midreset_rx_valid", rx_valid, 0);
    check("midreset_rx_busy", rx_busy, 0);
    check("midreset_rx_frame_err", rx_frame_err, 0);
    rx = 1'b1;
    idle(5);
    reset_n = 1'b1;
    last_good = '0;
    idle(20);
    check("post_reset_idle", rx_busy, 0);
    send_frame(8'h42, 1'b1, 1'b0);
    idle(10);

    // Continuous serial stream of every byte value.
    for (int k = 0; k < 256; k++) send_frame(DB'(k), 1'b1, 1'b0);
    idle(10);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(10);
`endif

    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
